// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module   : seq_addsub
// Function : Multi-cycle two's-complement adder/subtractor, W bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_addsub #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int            K      = N / W;
  localparam int            KW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  if ((W < 1) || ((N % W) != 0)) begin : g_width_check
    $error("seq_addsub: N must be a positive multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          carry_q;
  logic          op_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  result_q;
  logic          out_valid_q;
  logic          cout_q;
  logic          overflow_q;
  logic          zero_q;
  logic          negative_q;

  logic [31:0]   w_lo;
  logic [W-1:0]  w_a_chunk;
  logic [W-1:0]  w_b_chunk;
  logic [W-1:0]  w_a_eff;
  logic [W-1:0]  w_sum;
  logic          w_c_out;
  logic          w_c_msb_in;
  logic [N-1:0]  result_d;

  always_comb begin
    w_lo      = 32'(k_q) * 32'(W);
    w_a_chunk = a_q[w_lo +: W];
    w_b_chunk = b_q[w_lo +: W];
    w_a_eff   = op_q ? ~w_a_chunk : w_a_chunk;
    {w_c_out, w_sum} = {1'b0, w_b_chunk} + {1'b0, w_a_eff} + {{W{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the sum bit: s = a ^ b ^ cin.
    w_c_msb_in = w_sum[W-1] ^ w_b_chunk[W-1] ^ w_a_eff[W-1];
    result_d   = result_q;
    result_d[w_lo +: W] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op;
            k_q     <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          result_q <= result_d;
          carry_q  <= w_c_out;
          if (k_q == K_LAST) begin
            k_q         <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= w_c_out;
            overflow_q  <= w_c_msb_in ^ w_c_out;
            zero_q      <= (result_d == '0);
            negative_q  <= w_sum[W-1];
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule
`default_nettype wire
